// File: rtl/hart_issue_sched.sv
// Hart issue scheduler: primary-first selection with round-robin minors, per-hart penalty blocking and a minor-slot starvation guard.
// Selection is combinational (0 cycles); penalty/pointer effects land on the next unstalled edge; stall freezes all state.
module hart_issue_sched #(
    parameter int HART_NUM     = 4,
    parameter int HART_ID_W    = $clog2(HART_NUM),
    parameter int BR_PENALTY   = 2,
    parameter int LD_PENALTY   = 3,
    parameter int KILL_PENALTY = 4,
    parameter int MINOR_SLOT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [HART_NUM-1:0]  acti_hstate,
    input  logic [HART_NUM-1:0]  prim_hstate,
    input  logic                 is_branch,
    input  logic                 is_load,
    input  logic [HART_ID_W-1:0] id_hart_id,
    input  logic                 hkill,
    input  logic [HART_ID_W-1:0] kill_hart_id,
    output logic [HART_NUM-1:0]  issue_hstate,
    output logic [HART_ID_W-1:0] issue_hart_id,
    output logic                 issue_valid,
    output logic                 issue_primary
);

    localparam int SLOT_W = (MINOR_SLOT < 1) ? 1 : $clog2(MINOR_SLOT + 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(MINOR_SLOT);
    localparam logic SLOT_EN = (MINOR_SLOT != 0);
    localparam logic [3:0] BR_P = 4'(BR_PENALTY);
    localparam logic [3:0] LD_P = 4'(LD_PENALTY);
    localparam logic [3:0] KL_P = 4'(KILL_PENALTY);

    logic [3:0]           pcnt     [HART_NUM];
    logic [3:0]           pcnt_nxt [HART_NUM];
    logic [HART_ID_W-1:0] rr_last;
    logic [SLOT_W-1:0]    slot_cnt;

    logic [HART_NUM-1:0]  ready;
    logic [HART_NUM-1:0]  minor_ready;
    logic [HART_NUM-1:0]  prim_ready;
    logic [HART_NUM-1:0]  sel;
    logic [HART_ID_W-1:0] sel_id;
    logic                 rr_all;
    logic                 forced;
    logic                 sel_primary;

    // First set bit of mask strictly after 'last', wrapping modulo HART_NUM.
    function automatic logic [HART_NUM-1:0] rr_pick(input logic [HART_NUM-1:0]  mask,
                                                    input logic [HART_ID_W-1:0] last);
        logic [HART_NUM-1:0]  pick;
        logic [HART_ID_W-1:0] idx;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= HART_NUM; k++) begin
            idx = HART_ID_W'((int'(last) + k) % HART_NUM);
            if (!found && mask[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < HART_NUM; i++) begin
            ready[i] = acti_hstate[i] & (pcnt[i] == 4'd0);
        end
    end

    assign minor_ready = ready & ~prim_hstate;
    assign prim_ready  = ready & prim_hstate;
    assign rr_all      = (&acti_hstate) | (prim_hstate == '0);
    assign forced      = SLOT_EN && (slot_cnt == SLOT_MAX) && (minor_ready != '0);

    always_comb begin
        sel = '0;
        if (rr_all) begin
            sel = rr_pick(ready, rr_last);
        end else if ((prim_ready != '0) && !forced) begin
            sel = prim_ready;
        end else begin
            sel = rr_pick(minor_ready, rr_last);
        end
    end

    always_comb begin
        sel_id = '0;
        for (int i = 0; i < HART_NUM; i++) begin
            if (sel[i]) begin
                sel_id = HART_ID_W'(i);
            end
        end
    end

    assign sel_primary   = |(sel & prim_hstate);
    assign issue_hstate  = sel;
    assign issue_hart_id = sel_id;
    assign issue_valid   = |sel;
    assign issue_primary = sel_primary;

    // Simultaneous events on one hart take the longest penalty; an inactive hart is always unblocked.
    always_comb begin
        for (int i = 0; i < HART_NUM; i++) begin
            logic [3:0] ev;
            ev = 4'd0;
            if (is_branch && (id_hart_id == HART_ID_W'(i)) && (BR_P > ev)) ev = BR_P;
            if (is_load && (id_hart_id == HART_ID_W'(i)) && (LD_P > ev)) ev = LD_P;
            if (hkill && (kill_hart_id == HART_ID_W'(i)) && (KL_P > ev)) ev = KL_P;
            if (!acti_hstate[i]) begin
                pcnt_nxt[i] = 4'd0;
            end else if (ev != 4'd0) begin
                pcnt_nxt[i] = ev;
            end else if (pcnt[i] != 4'd0) begin
                pcnt_nxt[i] = pcnt[i] - 4'd1;
            end else begin
                pcnt_nxt[i] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HART_NUM; i++) begin
                pcnt[i] <= 4'd0;
            end
        end else if (!stall) begin
            for (int i = 0; i < HART_NUM; i++) begin
                pcnt[i] <= pcnt_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last  <= HART_ID_W'(HART_NUM - 1);
            slot_cnt <= '0;
        end else if (!stall) begin
            if (issue_valid && (rr_all || !sel_primary)) begin
                rr_last <= sel_id;
            end
            if ((minor_ready == '0) || (issue_valid && !sel_primary)) begin
                slot_cnt <= '0;
            end else if (sel_primary && (slot_cnt != SLOT_MAX)) begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hart_issue_sched.sv
// Bench for hart_issue_sched: directed scenarios plus randomized traffic against a queue/array reference model.
module tb_hart_issue_sched;

    localparam int HN  = 4;
    localparam int IW  = 2;
    localparam int BRP = 2;
    localparam int LDP = 3;
    localparam int KLP = 4;
    localparam int MS  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [HN-1:0] acti_hstate;
    logic [HN-1:0] prim_hstate;
    logic          is_branch;
    logic          is_load;
    logic [IW-1:0] id_hart_id;
    logic          hkill;
    logic [IW-1:0] kill_hart_id;
    logic [HN-1:0] issue_hstate;
    logic [IW-1:0] issue_hart_id;
    logic          issue_valid;
    logic          issue_primary;

    always #5 clk = ~clk;

    hart_issue_sched #(
        .HART_NUM(HN), .HART_ID_W(IW), .BR_PENALTY(BRP), .LD_PENALTY(LDP),
        .KILL_PENALTY(KLP), .MINOR_SLOT(MS)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .acti_hstate(acti_hstate), .prim_hstate(prim_hstate),
        .is_branch(is_branch), .is_load(is_load), .id_hart_id(id_hart_id),
        .hkill(hkill), .kill_hart_id(kill_hart_id),
        .issue_hstate(issue_hstate), .issue_hart_id(issue_hart_id),
        .issue_valid(issue_valid), .issue_primary(issue_primary)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: remaining blocked cycles per hart, last round-robin winner, primary streak.
    int            m_pcnt [HN];
    int            m_rr;
    int            m_slot;
    int            e_sel;
    bit            e_rrall;
    logic [HN-1:0] e_ready;
    logic [HN-1:0] e_minor;
    logic [HN-1:0] obs_hs;
    logic          obs_vld;
    logic          obs_pr;

    function automatic int rr_from(input logic [HN-1:0] m, input int last);
        int j;
        for (int k = 1; k <= HN; k++) begin
            j = (last + k) % HN;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) m_pcnt[i] = 0;
        m_rr   = HN - 1;
        m_slot = 0;
    endtask

    task automatic model_eval();
        bit forced;
        int p;
        e_rrall = (acti_hstate == '1) || (prim_hstate == '0);
        for (int i = 0; i < HN; i++) e_ready[i] = acti_hstate[i] && (m_pcnt[i] == 0);
        e_minor = e_ready & ~prim_hstate;
        forced  = (MS != 0) && (m_slot == MS) && (e_minor != '0);
        p = -1;
        for (int i = 0; i < HN; i++) if (prim_hstate[i]) p = i;
        if (e_rrall)                             e_sel = rr_from(e_ready, m_rr);
        else if (p >= 0 && e_ready[p] && !forced) e_sel = p;
        else                                     e_sel = rr_from(e_minor, m_rr);
    endtask

    task automatic model_update();
        bit is_prim;
        int ev;
        is_prim = (e_sel >= 0) && prim_hstate[e_sel];
        if (e_sel >= 0 && (e_rrall || !is_prim)) m_rr = e_sel;
        if (e_minor == '0 || (e_sel >= 0 && !is_prim)) m_slot = 0;
        else if (is_prim && m_slot < MS)                m_slot = m_slot + 1;
        for (int i = 0; i < HN; i++) begin
            ev = 0;
            if (is_branch && int'(id_hart_id) == i && BRP > ev) ev = BRP;
            if (is_load && int'(id_hart_id) == i && LDP > ev)   ev = LDP;
            if (hkill && int'(kill_hart_id) == i && KLP > ev)   ev = KLP;
            if (!acti_hstate[i])   m_pcnt[i] = 0;
            else if (ev > 0)       m_pcnt[i] = ev;
            else if (m_pcnt[i] > 0) m_pcnt[i] = m_pcnt[i] - 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [HN-1:0] exp_hs;
        model_eval();
        exp_hs = '0;
        if (e_sel >= 0) exp_hs[e_sel] = 1'b1;
        check_eq({tag, ".hstate"}, 32'(issue_hstate), 32'(exp_hs));
        check_eq({tag, ".id"}, 32'(issue_hart_id), (e_sel >= 0) ? 32'(e_sel) : 32'd0);
        check_eq({tag, ".valid"}, 32'(issue_valid), 32'(e_sel >= 0));
        check_eq({tag, ".primary"}, 32'(issue_primary), 32'((e_sel >= 0) && prim_hstate[e_sel]));
        obs_hs  = issue_hstate;
        obs_vld = issue_valid;
        obs_pr  = issue_primary;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input string tag, input logic st, input logic [HN-1:0] ac,
                         input logic [HN-1:0] pr, input logic br, input logic ld,
                         input logic [IW-1:0] idh, input logic kl, input logic [IW-1:0] kh);
        stall = st; acti_hstate = ac; prim_hstate = pr;
        is_branch = br; is_load = ld; id_hart_id = idh; hkill = kl; kill_hart_id = kh;
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (rst && !st) model_update();
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic [HN-1:0] ac, input logic [HN-1:0] pr,
                        input logic [HN-1:0] exp);
        cycle(tag, 1'b0, ac, pr, 1'b0, 1'b0, '0, 1'b0, '0);
        check_eq({tag, ".seq"}, 32'(obs_hs), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0; acti_hstate = '0; prim_hstate = '0;
        is_branch = 1'b0; is_load = 1'b0; id_hart_id = '0; hkill = 1'b0; kill_hart_id = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [HN-1:0] seq1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [HN-1:0] seq2 [4] = '{4'b0010, 4'b0100, 4'b0010, 4'b0001};
    logic [HN-1:0] r_ac, r_pr;
    int            r;

    initial begin
        @(negedge clk);
        do_reset();
        #1;
        check_eq("reset.valid", 32'(issue_valid), 32'd0);
        check_eq("reset.hstate", 32'(issue_hstate), 32'd0);

        // Pure interleave when all harts are active.
        for (int i = 0; i < 5; i++) idle("interleave", 4'b1111, 4'b0001, seq1[i]);

        // Primary load penalty hands slots to minors, then primary resumes.
        do_reset();
        cycle("ld_ev", 1'b0, 4'b0111, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, '0);
        check_eq("ld_ev.seq", 32'(obs_hs), 32'b0001);
        for (int i = 0; i < 4; i++) idle("ld_pen", 4'b0111, 4'b0001, seq2[i]);
        check_eq("ld_pen.primary_back", 32'(obs_pr), 32'd1);

        // Starvation guard forces one minor slot after MS primary issues.
        do_reset();
        for (int i = 0; i < MS; i++) idle("slot_a", 4'b0111, 4'b0001, 4'b0001);
        idle("slot_minor1", 4'b0111, 4'b0001, 4'b0010);
        for (int i = 0; i < MS; i++) idle("slot_b", 4'b0111, 4'b0001, 4'b0001);
        idle("slot_minor2", 4'b0111, 4'b0001, 4'b0100);

        // Kill and branch on the same hart: the longer kill penalty wins.
        do_reset();
        cycle("kill_br", 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b1, 2'd1);
        check_eq("kill_br.seq", 32'(obs_hs), 32'b0010);
        for (int i = 0; i < KLP; i++) idle("kill_blk", 4'b0010, 4'b0000, 4'b0000);
        idle("kill_free", 4'b0010, 4'b0000, 4'b0010);

        // Stall mid-penalty freezes the counter; events during stall are dropped.
        do_reset();
        cycle("stl_ev", 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, '0);
        check_eq("stl_ev.seq", 32'(obs_hs), 32'b0010);
        idle("stl_pre", 4'b0010, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cycle("stl_hold", 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1);
            check_eq("stl_hold.seq", 32'(obs_hs), 32'b0000);
        end
        idle("stl_rel1", 4'b0010, 4'b0000, 4'b0000);
        idle("stl_rel2", 4'b0010, 4'b0000, 4'b0000);
        idle("stl_rel3", 4'b0010, 4'b0000, 4'b0010);

        // Async reset mid-cycle clears blocking immediately.
        do_reset();
        cycle("ar_ev", 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, '0);
        check_eq("ar_ev.seq", 32'(obs_hs), 32'b0001);
        idle("ar_blk", 4'b0001, 4'b0001, 4'b0000);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("ar_now");
        check_eq("ar_now.seq", 32'(obs_hs), 32'b0001);
        @(negedge clk);
        cycle("ar_acti0", 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, '0, 1'b0, '0);
        check_eq("ar_acti0.valid", 32'(obs_vld), 32'd0);
        rst = 1'b1;

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r_ac = ($urandom_range(0, 3) == 0) ? 4'b1111 : HN'($urandom_range(0, (1 << HN) - 1));
            r = $urandom_range(0, HN);
            r_pr = (r == HN) ? '0 : HN'(1 << r);
            cycle("rnd", ($urandom_range(0, 7) == 0), r_ac, r_pr,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  IW'($urandom_range(0, HN - 1)), ($urandom_range(0, 9) == 0),
                  IW'($urandom_range(0, HN - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
